// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microprogram sequencer: condition codes, FSM
// state encodings and decode-address field layout.
package micro_sequencer_pkg;

    localparam logic [2:0] COND_NEXT   = 3'b000;
    localparam logic [2:0] COND_N      = 3'b001;
    localparam logic [2:0] COND_Z      = 3'b010;
    localparam logic [2:0] COND_V      = 3'b011;
    localparam logic [2:0] COND_C      = 3'b100;
    localparam logic [2:0] COND_IR13   = 3'b101;
    localparam logic [2:0] COND_JUMP   = 3'b110;
    localparam logic [2:0] COND_DECODE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_WAIT  = 2'b10,
        ST_ERROR = 2'b11
    } seq_state_t;

    // Flag positions inside PSR {n,z,v,c}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam int IR_OP_HI      = 31;
    localparam int IR_OP_LO      = 30;
    localparam int IR_OP2_HI     = 24;
    localparam int IR_OP2_LO     = 22;
    localparam int IR_OP3_HI     = 24;
    localparam int IR_OP3_LO     = 19;
    localparam int IR_BRANCH_BIT = 13;

    localparam logic DECODE_LEAD = 1'b1;

endpackage

// File: rtl/micro_sequencer_next_addr.sv
// Combinational next control-store address: branch evaluation, incrementer
// and next/jump/decode select.
module micro_sequencer_next_addr
    import micro_sequencer_pkg::*;
#(
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_IR          = 32
) (
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] upc,
    input  logic [DATAWIDTH_CONDITION-1:0]   cond,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] jump_addr,
    input  logic [DATAWIDTH_IR-1:0]          ir,
    input  logic [3:0]                       flags,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr
);

    localparam logic [DATAWIDTH_JUMPADDRESS-1:0] ADDR_ONE = 1;

    logic [DATAWIDTH_JUMPADDRESS-1:0] inc_addr;
    logic [DATAWIDTH_JUMPADDRESS-1:0] decode_addr;
    logic [1:0]                       op;
    logic                             taken;
    logic                             unused_ir;

    assign inc_addr  = upc + ADDR_ONE;
    assign op        = ir[IR_OP_HI:IR_OP_LO];
    assign unused_ir = ^{ir[29:25], ir[18:14], ir[12:0]};

    always_comb begin
        decode_addr = '0;
        case (op)
            2'b00:   decode_addr = {DECODE_LEAD, 2'b00, ir[IR_OP2_HI:IR_OP2_LO], 3'b000, 2'b00};
            2'b01:   decode_addr = {DECODE_LEAD, 2'b01, 6'b000000, 2'b00};
            default: decode_addr = {DECODE_LEAD, op, ir[IR_OP3_HI:IR_OP3_LO], 2'b00};
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_N:    taken = flags[FLAG_N];
            COND_Z:    taken = flags[FLAG_Z];
            COND_V:    taken = flags[FLAG_V];
            COND_C:    taken = flags[FLAG_C];
            COND_IR13: taken = ir[IR_BRANCH_BIT];
            COND_JUMP: taken = 1'b1;
            default:   taken = 1'b0;
        endcase

        if (cond == COND_DECODE) begin
            next_addr = decode_addr;
        end else if (taken) begin
            next_addr = jump_addr;
        end else begin
            next_addr = inc_addr;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer top: uPC register, memory-stall FSM, wait-timeout
// counter and sticky error flag.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_IR          = 32,
    parameter int DATAWIDTH_TIMEOUT     = 8,
    parameter int TIMEOUT               = 255
) (
    input  logic                             MICRO_SEQUENCER_CLOCK_50,
    input  logic                             MICRO_SEQUENCER_ResetInHigh_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   MICRO_SEQUENCER_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_JumpAddress_InBus,
    input  logic                             MICRO_SEQUENCER_RD_In,
    input  logic                             MICRO_SEQUENCER_WRMain_In,
    input  logic                             MICRO_SEQUENCER_MemReady_In,
    input  logic [DATAWIDTH_IR-1:0]          MICRO_SEQUENCER_IR_InBus,
    input  logic [3:0]                       MICRO_SEQUENCER_Flags_InBus,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_CSAddress_OutBus,
    output logic                             MICRO_SEQUENCER_Commit_Out,
    output logic [1:0]                       MICRO_SEQUENCER_State_OutBus,
    output logic                             MICRO_SEQUENCER_Error_Out
);

    localparam logic [DATAWIDTH_TIMEOUT-1:0] CNT_ONE  = 1;
    localparam logic [DATAWIDTH_TIMEOUT-1:0] CNT_LAST = DATAWIDTH_TIMEOUT'(TIMEOUT - 1);

    seq_state_t                       state_q, state_d;
    logic [DATAWIDTH_JUMPADDRESS-1:0] upc_q, upc_d;
    logic [DATAWIDTH_TIMEOUT-1:0]     count_q, count_d;
    logic                             error_q, error_d;
    logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr;
    logic                             memreq;
    logic                             commit;

    assign memreq = MICRO_SEQUENCER_RD_In | MICRO_SEQUENCER_WRMain_In;

    micro_sequencer_next_addr #(
        .DATAWIDTH_CONDITION  (DATAWIDTH_CONDITION),
        .DATAWIDTH_JUMPADDRESS(DATAWIDTH_JUMPADDRESS),
        .DATAWIDTH_IR         (DATAWIDTH_IR)
    ) u_next_addr (
        .upc      (upc_q),
        .cond     (MICRO_SEQUENCER_Condition_InBus),
        .jump_addr(MICRO_SEQUENCER_JumpAddress_InBus),
        .ir       (MICRO_SEQUENCER_IR_InBus),
        .flags    (MICRO_SEQUENCER_Flags_InBus),
        .next_addr(next_addr)
    );

    always_ff @(posedge MICRO_SEQUENCER_CLOCK_50) begin
        if (MICRO_SEQUENCER_ResetInHigh_In) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        count_d = count_q;
        error_d = error_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                upc_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (memreq && !MICRO_SEQUENCER_MemReady_In) begin
                    state_d = ST_WAIT;
                    count_d = '0;
                end else begin
                    commit = 1'b1;
                    upc_d  = next_addr;
                end
            end
            ST_WAIT: begin
                count_d = count_q + CNT_ONE;
                if (MICRO_SEQUENCER_MemReady_In) begin
                    commit  = 1'b1;
                    upc_d   = next_addr;
                    state_d = ST_RUN;
                end else if (count_q == CNT_LAST) begin
                    // Error flag and uPC clear land together with the state change
                    state_d = ST_ERROR;
                    upc_d   = '0;
                    error_d = 1'b1;
                end
            end
            default: begin
                upc_d   = '0;
                error_d = 1'b1;
            end
        endcase
    end

    assign MICRO_SEQUENCER_CSAddress_OutBus = upc_q;
    assign MICRO_SEQUENCER_Commit_Out       = commit;
    assign MICRO_SEQUENCER_State_OutBus     = state_q;
    assign MICRO_SEQUENCER_Error_Out        = error_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: per-cycle comparison against an
// arithmetic model plus directed literal checks.
module tb_micro_sequencer;

    localparam int TO = 4;
    localparam logic [31:0] IR_ADDCC = {2'b10, 5'b00000, 6'b010000, 19'd0};
    localparam logic [31:0] IR_OP00  = {2'b00, 5'b00000, 3'b101, 22'd0};
    localparam logic [31:0] IR_OP01  = 32'h4000_0000;
    localparam logic [31:0] IR_B13   = 32'h0000_2000;

    logic        clk;
    logic        rst;
    logic [2:0]  cond;
    logic [10:0] jump;
    logic        rd;
    logic        wr;
    logic        ready;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic [10:0] cs;
    logic        commit;
    logic [1:0]  state;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    micro_sequencer #(.TIMEOUT(TO)) dut (
        .MICRO_SEQUENCER_CLOCK_50         (clk),
        .MICRO_SEQUENCER_ResetInHigh_In   (rst),
        .MICRO_SEQUENCER_Condition_InBus  (cond),
        .MICRO_SEQUENCER_JumpAddress_InBus(jump),
        .MICRO_SEQUENCER_RD_In            (rd),
        .MICRO_SEQUENCER_WRMain_In        (wr),
        .MICRO_SEQUENCER_MemReady_In      (ready),
        .MICRO_SEQUENCER_IR_InBus         (ir),
        .MICRO_SEQUENCER_Flags_InBus      (flags),
        .MICRO_SEQUENCER_CSAddress_OutBus (cs),
        .MICRO_SEQUENCER_Commit_Out       (commit),
        .MICRO_SEQUENCER_State_OutBus     (state),
        .MICRO_SEQUENCER_Error_Out        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next address computed from the address arithmetic of the decode rules
    function automatic int model_next(input int upc, input int c, input int j,
                                      input logic [31:0] i, input logic [3:0] f);
        int inc;
        int op;
        inc = (upc + 1) % 2048;
        op  = int'(i[31:30]);
        case (c)
            1: return f[3] ? j : inc;
            2: return f[2] ? j : inc;
            3: return f[1] ? j : inc;
            4: return f[0] ? j : inc;
            5: return i[13] ? j : inc;
            6: return j;
            7: begin
                if (op == 0) return 1024 + int'(i[24:22]) * 32;
                if (op == 1) return 1280;
                return 1024 + op * 256 + int'(i[24:19]) * 4;
            end
            default: return inc;
        endcase
    endfunction

    // Model: 0 idle, 1 run, 2 wait, 3 error
    int m_state;
    int m_upc;
    int m_waits;
    int m_err;
    bit m_valid = 1'b0;

    always @(negedge clk) begin
        int  exp_commit;
        int  nxt;
        bit  stall;
        stall      = (rd || wr) && !ready;
        nxt        = model_next(m_upc, int'(cond), int'(jump), ir, flags);
        exp_commit = 0;
        if (m_state == 1 && !stall) exp_commit = 1;
        if (m_state == 2 && ready)  exp_commit = 1;
        if (m_valid) begin
            chk("cycle_state",  int'(state),  m_state);
            chk("cycle_upc",    int'(cs),     m_upc);
            chk("cycle_commit", int'(commit), exp_commit);
            chk("cycle_error",  int'(err),    m_err);
        end
        if (rst) begin
            m_state = 0; m_upc = 0; m_waits = 0; m_err = 0;
            m_valid = 1'b1;
        end else if (m_state == 0) begin
            m_state = 1; m_upc = 0;
        end else if (m_state == 1) begin
            if (stall) begin
                m_state = 2; m_waits = 0;
            end else begin
                m_upc = nxt;
            end
        end else if (m_state == 2) begin
            m_waits++;
            if (ready) begin
                m_state = 1; m_upc = nxt;
            end else if (m_waits == TO) begin
                m_state = 3; m_upc = 0; m_err = 1;
            end
        end else begin
            m_upc = 0; m_err = 1;
        end
    end

    task automatic drive(input logic [2:0] c, input int j, input logic r, input logic w,
                         input logic m, input logic [31:0] i, input logic [3:0] f);
        cond  = c;
        jump  = 11'(j);
        rd    = r;
        wr    = w;
        ready = m;
        ir    = i;
        flags = f;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(3'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        step(); step();
        chk("reset_upc", int'(cs), 0);
        chk("reset_state", int'(state), 0);
        chk("reset_commit", int'(commit), 0);
        chk("reset_error", int'(err), 0);

        rst = 1'b0;
        drive(3'd0, 0, 1'b1, 1'b0, 1'b1, 32'd0, 4'd0);
        chk("idle_bubble_state", int'(state), 0);
        chk("idle_bubble_commit", int'(commit), 0);
        step();
        chk("first_run_state", int'(state), 1);
        chk("first_run_commit", int'(commit), 1);
        chk("first_run_upc", int'(cs), 0);
        step();
        chk("fetch_inc", int'(cs), 1);

        drive(3'd7, 0, 1'b0, 1'b0, 1'b0, IR_ADDCC, 4'd0);
        step();
        chk("decode_addcc", int'(cs), 1600);
        drive(3'd5, 1692, 1'b0, 1'b0, 1'b0, IR_B13, 4'd0);
        step();
        chk("ir13_taken", int'(cs), 1692);
        drive(3'd6, 1600, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        step();
        chk("jump_back", int'(cs), 1600);
        drive(3'd5, 1692, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        step();
        chk("ir13_not_taken", int'(cs), 1601);

        drive(3'd0, 0, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0);
        chk("stall_run_commit", int'(commit), 0);
        step();
        chk("stall_wait_state", int'(state), 2);
        chk("stall_hold1", int'(cs), 1601);
        step();
        chk("stall_hold2", int'(cs), 1601);
        step();
        drive(3'd0, 0, 1'b1, 1'b0, 1'b1, 32'd0, 4'd0);
        chk("stall_release_commit", int'(commit), 1);
        chk("stall_hold3", int'(cs), 1601);
        step();
        chk("stall_back_run", int'(state), 1);
        chk("stall_advance", int'(cs), 1602);

        drive(3'd0, 0, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0);
        step(); step(); step(); step();
        chk("timeout_still_wait", int'(state), 2);
        step();
        chk("timeout_error_state", int'(state), 3);
        chk("timeout_error_flag", int'(err), 1);
        chk("timeout_upc_zero", int'(cs), 0);
        drive(3'd0, 0, 1'b0, 1'b1, 1'b1, 32'd0, 4'd0);
        chk("error_ignores_ready", int'(commit), 0);
        step();
        chk("error_sticky", int'(err), 1);
        rst = 1'b1;
        step();
        chk("error_reset_state", int'(state), 0);
        chk("error_reset_flag", int'(err), 0);
        rst = 1'b0;

        drive(3'd6, 2047, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        step(); step();
        chk("jump_2047", int'(cs), 2047);
        drive(3'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        step();
        chk("wrap_zero", int'(cs), 0);
        drive(3'd6, 2046, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        step();
        chk("jump_2046", int'(cs), 2046);
        drive(3'd1, 100, 1'b0, 1'b0, 1'b0, 32'd0, 4'b0000);
        step();
        chk("n_not_taken", int'(cs), 2047);
        drive(3'd1, 100, 1'b0, 1'b0, 1'b0, 32'd0, 4'b1000);
        step();
        chk("n_taken", int'(cs), 100);
        drive(3'd2, 200, 1'b1, 1'b0, 1'b1, 32'd0, 4'b0100);
        step();
        chk("z_taken", int'(cs), 200);
        drive(3'd3, 300, 1'b0, 1'b0, 1'b0, 32'd0, 4'b0000);
        step();
        chk("v_not_taken", int'(cs), 201);
        drive(3'd4, 300, 1'b0, 1'b0, 1'b0, 32'd0, 4'b0001);
        step();
        chk("c_taken", int'(cs), 300);
        drive(3'd7, 0, 1'b0, 1'b0, 1'b0, IR_OP00, 4'd0);
        step();
        chk("decode_op00", int'(cs), 1184);
        drive(3'd7, 0, 1'b0, 1'b0, 1'b0, IR_OP01, 4'd0);
        step();
        chk("decode_op01", int'(cs), 1280);

        drive(3'd0, 0, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0);
        step();
        chk("midwait_state", int'(state), 2);
        rst = 1'b1;
        step();
        chk("midwait_reset_state", int'(state), 0);
        chk("midwait_reset_upc", int'(cs), 0);
        rst = 1'b0;
        drive(3'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        step();
        chk("restart_run", int'(state), 1);
        step();
        chk("restart_inc", int'(cs), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
